// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feeder
// Description : Operand sequencer for a SIZE x SIZE MAC systolic array.
//               Buffers one A and one B matrix of bytes. On start it clears
//               the array accumulators, then streams diagonally skewed
//               operands onto the row and column edges. The mult/acc enables
//               are sequenced so that the array ends up holding C = A x B.
//               Optional build macro SYSTOLIC_FEEDER_TRANSPOSE_B_EN: each
//               b_wr_en write stores wr_data as one column of B, so B can be
//               loaded as B-transpose rows.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_feeder #(
  parameter int SIZE = 4
) (
  input  logic                      clk,
  input  logic                      reset,     // asynchronous, active-low
  input  logic                      a_wr_en,
  input  logic                      b_wr_en,
  input  logic [$clog2(SIZE)-1:0]   wr_row,
  input  logic [SIZE-1:0][7:0]      wr_data,
  input  logic                      start,
  output logic [SIZE-1:0][7:0]      a_out,
  output logic [SIZE-1:0][7:0]      b_out,
  output logic                      load_en,
  output logic                      mult_en,
  output logic                      acc_en,
  output logic                      busy,
  output logic                      done
);

  localparam int TW = $clog2(3*SIZE);
  localparam int IW = $clog2(SIZE);
  localparam logic [TW-1:0] T_LAST = TW'(3*SIZE-3);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic [TW-1:0]        t_q;
  logic [SIZE-1:0][7:0] a_out_q, b_out_q;
  logic                 load_en_q, mult_en_q, acc_en_q, busy_q, done_q;

  // Operand buffers: one packed row per entry, not affected by reset.
  logic [SIZE-1:0][7:0] a_buf_q [SIZE];
  logic [SIZE-1:0][7:0] b_buf_q [SIZE];

  // Skewed operand vectors for the step that the next edge will present.
  logic [TW-1:0]        sel_t_d;
  logic [SIZE-1:0][7:0] a_skew_d, b_skew_d;

  assign a_out   = a_out_q;
  assign b_out   = b_out_q;
  assign load_en = load_en_q;
  assign mult_en = mult_en_q;
  assign acc_en  = acc_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Buffer writes are locked out while a run is in progress.
  always_ff @(posedge clk) begin
    if (a_wr_en && !busy_q) begin
      a_buf_q[wr_row] <= wr_data;
    end
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
    if (b_wr_en && !busy_q) begin
      for (int k = 0; k < SIZE; k++) begin
        b_buf_q[k][wr_row] <= wr_data[k];
      end
    end
`else
    if (b_wr_en && !busy_q) begin
      b_buf_q[wr_row] <= wr_data;
    end
`endif
  end

  // CLEAR always hands over to RUN step 0; within RUN the next step is t+1.
  assign sel_t_d = (state_q == S_RUN) ? (t_q + TW'(1)) : '0;

  // Diagonal skew: row i sees A[i][t-i], column j sees B[t-j][j], zero outside.
  always_comb begin
    logic [TW-1:0] diff;
    diff     = '0;
    a_skew_d = '0;
    b_skew_d = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (sel_t_d >= TW'(i)) begin
        diff = sel_t_d - TW'(i);
        if (diff < TW'(SIZE)) begin
          a_skew_d[i] = a_buf_q[i][diff[IW-1:0]];
          b_skew_d[i] = b_buf_q[diff[IW-1:0]][i];
        end
      end
    end
  end

  // Run sequencer with registered outputs computed for the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      a_out_q   <= '0;
      b_out_q   <= '0;
      load_en_q <= 1'b0;
      mult_en_q <= 1'b0;
      acc_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      a_out_q   <= '0;
      b_out_q   <= '0;
      load_en_q <= 1'b0;
      mult_en_q <= 1'b0;
      acc_en_q  <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          t_q <= '0;
          if (start) begin
            state_q   <= S_CLEAR;
            load_en_q <= 1'b1;
            busy_q    <= 1'b1;
          end else begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
          end
        end
        S_CLEAR: begin
          state_q   <= S_RUN;
          t_q       <= '0;
          mult_en_q <= 1'b1;
          acc_en_q  <= 1'b1;
          busy_q    <= 1'b1;
          a_out_q   <= a_skew_d;
          b_out_q   <= b_skew_d;
        end
        S_RUN: begin
          if (t_q == T_LAST) begin
            state_q <= S_DONE;
            t_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            t_q       <= sel_t_d;
            mult_en_q <= 1'b1;
            acc_en_q  <= 1'b1;
            busy_q    <= 1'b1;
            a_out_q   <= a_skew_d;
            b_out_q   <= b_skew_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          t_q     <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
